// File: rtl/axi4_cmd_master_pkg.sv
// Shared types and constants for the AXI4 command master.
// State codes, burst/response encodings and a response merge helper.
package axi4_cmd_master_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_AR   = 3'd1;
    localparam state_t ST_R    = 3'd2;
    localparam state_t ST_AW   = 3'd3;
    localparam state_t ST_W    = 3'd4;
    localparam state_t ST_B    = 3'd5;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Worst-of merge: higher encodings are the more severe responses.
    function automatic logic [1:0] resp_max(
        input logic [1:0] a,
        input logic [1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi4_beat_counter.sv
// Burst beat counter with last-beat compare and handshake watchdog.
// The beat count holds on the final beat, so len=255 never wraps.
module axi4_beat_counter #(
    parameter int TIMEOUT = 256
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       beat_i,
    input  logic       busy_i,
    input  logic       hs_i,
    input  logic [7:0] len_i,
    output logic       last_o,
    output logic       timeout_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [7:0]    cnt_q, cnt_d;
    logic [CW-1:0] idle_q, idle_d;
    logic          to_q, to_d;

    assign last_o    = (cnt_q == len_i);
    assign timeout_o = to_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (beat_i && !last_o) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counts cycles without any AXI handshake while a command is in flight.
    always_comb begin
        idle_d = idle_q;
        to_d   = to_q;
        if (!busy_i || hs_i) begin
            idle_d = '0;
        end else begin
            if (idle_q != CW'(TIMEOUT)) begin
                idle_d = idle_q + 1'b1;
            end
            if (idle_q == CW'(TIMEOUT - 1)) begin
                to_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= 8'd0;
            idle_q <= '0;
            to_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idle_q <= idle_d;
            to_q   <= to_d;
        end
    end

endmodule

// File: rtl/axi4_cmd_master.sv
// Single-outstanding AXI4 burst master driven by a simple command port.
// Read beats stream straight to the sink; write beats from the source.
module axi4_cmd_master
    import axi4_cmd_master_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [7:0]  cmd_len,
    input  logic [2:0]  cmd_size,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_strb,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        rd_last,
    input  logic        rd_ready,
    output logic        done,
    output logic [1:0]  resp,
    output logic        timeout,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    output logic [2:0]  arsize,
    output logic [7:0]  arlen,
    output logic [1:0]  arburst,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    input  logic        rlast,
    input  logic [1:0]  rresp,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [2:0]  awsize,
    output logic [7:0]  awlen,
    output logic [1:0]  awburst,
    output logic [31:0] wdata,
    output logic        wvalid,
    input  logic        wready,
    output logic [3:0]  wstrb,
    output logic        wlast,
    input  logic        bvalid,
    output logic        bready,
    input  logic [1:0]  bresp
);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  resp_q, resp_d;
    logic        done_q, done_d;
    logic        live_q;

    logic st_idle, st_ar, st_r, st_aw, st_w, st_b;
    logic accept, last;
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

    assign st_idle = (state_q == ST_IDLE);
    assign st_ar   = (state_q == ST_AR);
    assign st_r    = (state_q == ST_R);
    assign st_aw   = (state_q == ST_AW);
    assign st_w    = (state_q == ST_W);
    assign st_b    = (state_q == ST_B);

    // live_q keeps cmd_ready low while reset is asserted.
    assign cmd_ready = st_idle & live_q;
    assign accept    = cmd_valid & cmd_ready;

    assign arvalid = st_ar;
    assign araddr  = st_ar ? addr_q : 32'd0;
    assign arlen   = st_ar ? len_q : 8'd0;
    assign arsize  = st_ar ? size_q : 3'd0;
    assign arburst = st_ar ? BURST_INCR : 2'b00;

    assign rready   = st_r & rd_ready;
    assign rd_valid = st_r & rvalid;
    assign rd_data  = st_r ? rdata : 32'd0;
    assign rd_last  = st_r & last;

    assign awvalid = st_aw;
    assign awaddr  = st_aw ? addr_q : 32'd0;
    assign awlen   = st_aw ? len_q : 8'd0;
    assign awsize  = st_aw ? size_q : 3'd0;
    assign awburst = st_aw ? BURST_INCR : 2'b00;

    assign wvalid   = st_w & wr_valid;
    assign wdata    = st_w ? wr_data : 32'd0;
    assign wstrb    = st_w ? wr_strb : 4'd0;
    assign wlast    = st_w & last;
    assign wr_ready = st_w & wready;

    assign bready = st_b;

    assign ar_hs = arvalid & arready;
    assign r_hs  = rvalid & rready;
    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;
    assign b_hs  = bvalid & bready;

    assign done = done_q;
    assign resp = resp_q;

    axi4_beat_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_cnt (
        .clk_i     (PCLK),
        .rst_ni    (PRESETn),
        .clr_i     (accept),
        .beat_i    (r_hs | w_hs),
        .busy_i    (!st_idle),
        .hs_i      (ar_hs | r_hs | aw_hs | w_hs | b_hs),
        .len_i     (len_q),
        .last_o    (last),
        .timeout_o (timeout)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        resp_d  = resp_q;
        done_d  = 1'b0;
        unique case (1'b1)
            st_idle: begin
                if (accept) begin
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    size_d  = cmd_size;
                    resp_d  = RESP_OKAY;
                    state_d = cmd_write ? ST_AW : ST_AR;
                end
            end
            st_ar: begin
                if (arready) state_d = ST_R;
            end
            st_r: begin
                if (r_hs) begin
                    resp_d = resp_max(resp_q, rresp);
                    // A misplaced or missing rlast is a protocol error.
                    if (rlast != last) begin
                        resp_d = resp_max(resp_d, RESP_SLVERR);
                    end
                    if (last) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            st_aw: begin
                if (awready) state_d = ST_W;
            end
            st_w: begin
                if (w_hs && last) state_d = ST_B;
            end
            st_b: begin
                if (b_hs) begin
                    resp_d  = resp_max(resp_q, bresp);
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'd0;
            len_q   <= 8'd0;
            size_q  <= 3'd0;
            resp_q  <= RESP_OKAY;
            done_q  <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            resp_q  <= resp_d;
            done_q  <= done_d;
            live_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi4_cmd_master.sv
// Scoreboard bench for axi4_cmd_master with a behavioural AXI slave.
// Expected beats are queued at command time and popped on handshakes.
module tb_axi4_cmd_master;

    logic        clk = 1'b0;
    logic        PRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid, rd_last, rd_ready;
    logic        done, timeout;
    logic [1:0]  resp;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic        arvalid, arready, awvalid, awready;
    logic [2:0]  arsize, awsize;
    logic [7:0]  arlen, awlen;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        rvalid, rready, rlast;
    logic        wvalid, wready, wlast;
    logic [3:0]  wstrb;
    logic        bvalid, bready;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  s;
        logic        l;
    } beat_t;

    beat_t     exp_q[$];
    int        n_chk = 0;
    int        n_err = 0;
    logic [1:0] last_resp = 2'b00;

    always #5 clk = ~clk;

    axi4_cmd_master #(.TIMEOUT(16)) dut (
        .PCLK(clk), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_size(cmd_size),
        .wr_data(wr_data), .wr_strb(wr_strb),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_last(rd_last), .rd_ready(rd_ready),
        .done(done), .resp(resp), .timeout(timeout),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .arsize(arsize), .arlen(arlen), .arburst(arburst),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .rlast(rlast), .rresp(rresp),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .awsize(awsize), .awlen(awlen), .awburst(awburst),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] wd(input int i);
        return 32'h00f1001f + 32'h01000100 * i;
    endfunction

    function automatic logic [3:0] ws(input int i);
        logic [31:0] v;
        v = i;
        return 4'hF ^ v[3:0];
    endfunction

    function automatic logic [31:0] rdv(input int i);
        return 32'hC0DE0000 + i;
    endfunction

    task automatic idle_inputs();
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0;
        cmd_len = 0; cmd_size = 0;
        wr_data = 0; wr_strb = 0; wr_valid = 0; rd_ready = 0;
        arready = 0; awready = 0; wready = 0;
        rdata = 0; rvalid = 0; rlast = 0; rresp = 0;
        bvalid = 0; bresp = 0;
    endtask

    task automatic run_cmd(input logic wr, input logic [31:0] a,
                           input logic [7:0] ln, input logic [1:0] err,
                           input int stall, input bit nolast,
                           input int abort, input logic [1:0] exp_resp);
        int rb, wb, sb, cyc, stc;
        bit ar_ok, aw_ok, fin, w_early, ab;
        beat_t e;
        rb = 0; wb = 0; sb = 0; cyc = 0; stc = 0;
        ar_ok = 0; aw_ok = 0; fin = 0; w_early = 0; ab = 0;
        chk("resp_hold", resp, last_resp);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a;
        cmd_len = ln; cmd_size = 3'd2;
        for (int i = 0; i <= int'(ln); i++) begin
            if (wr) exp_q.push_back('{d: wd(i), s: ws(i), l: (i == int'(ln))});
            else    exp_q.push_back('{d: rdv(i), s: 4'h0, l: (i == int'(ln))});
        end
        #1;
        chk("cmd_ready", cmd_ready, 1);
        step();
        cmd_valid = 0;
        while (!fin && !ab && cyc < 2000) begin
            arready  = !ar_ok;
            awready  = !aw_ok;
            rvalid   = ar_ok && (rb <= int'(ln));
            rdata    = rdv(rb);
            rlast    = (rb == int'(ln)) && !nolast;
            rresp    = err;
            wr_valid = (wb <= int'(ln));
            wr_data  = wd(wb);
            wr_strb  = ws(wb);
            wready   = 1;
            bvalid   = aw_ok && (sb > int'(ln));
            bresp    = err;
            rd_ready = !(stall > 0 && rb == stall && stc < 3);
            #1;
            if (!wr && abort >= 0 && rb == abort) begin
                PRESETn = 0;
                ab = 1;
            end else begin
                if (wr && !aw_ok && wvalid) w_early = 1;
                if (arvalid && arready) begin
                    chk("araddr", araddr, a);
                    chk("arlen", arlen, ln);
                    chk("arsize", arsize, 2);
                    chk("arburst", arburst, 1);
                    ar_ok = 1;
                end
                if (awvalid && awready) begin
                    chk("awaddr", awaddr, a);
                    chk("awlen", awlen, ln);
                    chk("awsize", awsize, 2);
                    chk("awburst", awburst, 1);
                    aw_ok = 1;
                end
                if (!rd_ready) begin
                    chk("rready_stall", rready, 0);
                    stc++;
                end
                if (rd_valid && rd_ready) begin
                    if (exp_q.size() == 0) chk("rd_extra", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("rd_data", rd_data, e.d);
                        chk("rd_last", rd_last, e.l);
                    end
                end
                if (wvalid && wready) begin
                    if (exp_q.size() == 0) chk("w_extra", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("wdata", wdata, e.d);
                        chk("wstrb", wstrb, e.s);
                        chk("wlast", wlast, e.l);
                    end
                    sb++;
                end
                if (rvalid && rready) rb++;
                if (wr_valid && wr_ready) wb++;
                step();
                cyc++;
                if (done) fin = 1;
            end
        end
        idle_inputs();
        if (ab) begin
            exp_q.delete();
            return;
        end
        chk("done", fin, 1);
        chk("beats", wr ? sb : rb, int'(ln) + 1);
        chk("resp", resp, exp_resp);
        chk("sb_empty", exp_q.size(), 0);
        if (wr) chk("w_before_aw", w_early, 0);
        step();
        chk("done_pulse", done, 0);
        chk("ready_after", cmd_ready, 1);
        last_resp = exp_resp;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 0);
        chk({tag, "_arvalid"}, arvalid, 0);
        chk({tag, "_araddr"}, araddr, 0);
        chk({tag, "_arlen"}, arlen, 0);
        chk({tag, "_rready"}, rready, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_awvalid"}, awvalid, 0);
        chk({tag, "_wvalid"}, wvalid, 0);
        chk({tag, "_bready"}, bready, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_resp"}, resp, 0);
        chk({tag, "_timeout"}, timeout, 0);
    endtask

    initial begin
        idle_inputs();
        PRESETn = 0;
        #3;
        chk_reset_outs("rst");
        step();
        step();
        PRESETn = 1;
        step();
        chk("rel_ready", cmd_ready, 1);

        run_cmd(1, 32'h10000004, 8'd0, 2'b00, 0, 0, -1, 2'b00);
        run_cmd(0, 32'h10000004, 8'd1, 2'b00, 0, 0, -1, 2'b00);
        run_cmd(0, 32'h10000040, 8'd3, 2'b00, 1, 0, -1, 2'b00);
        run_cmd(1, 32'h10000100, 8'd2, 2'b10, 0, 0, -1, 2'b10);
        run_cmd(0, 32'h10000200, 8'd0, 2'b00, 0, 0, -1, 2'b00);
        run_cmd(0, 32'h10000300, 8'd2, 2'b00, 0, 1, -1, 2'b10);
        run_cmd(0, 32'h10000400, 8'd1, 2'b11, 0, 0, -1, 2'b11);
        run_cmd(1, 32'h10001000, 8'd255, 2'b00, 0, 0, -1, 2'b00);
        run_cmd(0, 32'h10002000, 8'd255, 2'b00, 0, 0, -1, 2'b00);

        run_cmd(0, 32'h10003000, 8'd3, 2'b00, 0, 0, 2, 2'b00);
        #1;
        chk_reset_outs("mid");
        step();
        PRESETn = 1;
        step();
        chk("mid_rel_ready", cmd_ready, 1);
        last_resp = 2'b00;
        run_cmd(0, 32'h10004000, 8'd0, 2'b00, 0, 0, -1, 2'b00);

        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h20000000;
        cmd_len = 8'd0; cmd_size = 3'd2;
        step();
        cmd_addr = 32'h30000000;
        for (int k = 1; k <= 15; k++) step();
        chk("to_before", timeout, 0);
        chk("to_busy_ready", cmd_ready, 0);
        chk("to_arvalid_pre", arvalid, 1);
        step();
        chk("to_set", timeout, 1);
        chk("to_arvalid", arvalid, 1);
        chk("to_araddr", araddr, 32'h20000000);
        step();
        step();
        chk("to_sticky", timeout, 1);
        idle_inputs();
        PRESETn = 0;
        #1;
        chk("to_rst", timeout, 0);
        chk("to_rst_arvalid", arvalid, 0);
        step();
        PRESETn = 1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/axi4_cmd_master.md
AXI4_CMD_MASTER -- requirements
Module: axi4_cmd_master

Interface
REQ-001 Parameter TIMEOUT, 256, idle-handshake cycles before the timeout flag sets.
REQ-002 PCLK  in  1  single clock; all logic on rising edge.
REQ-003 PRESETn  in  1  reset, asynchronous, active-low.
REQ-004 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-005 cmd_write  in  1  1=write burst, 0=read burst.
REQ-006 cmd_addr  in  32  start address.
REQ-007 cmd_len, cmd_size  in  8, 3  AXI len (beats-1) and size.
REQ-008 wr_data, wr_strb, wr_valid, wr_ready  in/in/in/out  32/4/1/1  write-beat source stream.
REQ-009 rd_data, rd_valid, rd_last, rd_ready  out/out/out/in  32/1/1/1  read-beat sink stream.
REQ-010 done, resp, timeout  out  1/2/1  completion pulse, worst response, sticky timeout.
REQ-011 AXI4 master: ar{addr,valid,ready,size,len,burst}, r{data,valid,ready,last,resp}, aw{addr,valid,ready,size,len,burst}, w{data,valid,ready,strb,last}, b{valid,ready,resp}; widths 32/1/1/3/8/2, data 32, strb 4, resp 2.

Function
REQ-012 States IDLE, AR, R, AW, W, B; one transaction outstanding.
REQ-013 IDLE: cmd_ready=1; on cmd_valid latch cmd fields, go AR (read) or AW (write).
REQ-014 AR: arvalid=1, araddr/arlen/arsize from latch, arburst=2'b01; hold stable until arready; then R.
REQ-015 R: rready=rd_ready; rd_data=rdata, rd_valid=rvalid, same cycle (no buffering); beat counts on rvalid&rready.
REQ-016 R exits on final beat (count==len); done=1 that cycle's next edge, back to IDLE.
REQ-017 rlast early or absent on final beat: resp=2'b10 (SLVERR), burst still ends on count==len; rd_last=count==len.
REQ-018 AW: awvalid=1, awburst=2'b01, fields stable until awready; then W (no W before AW accepted).
REQ-019 W: wvalid=wr_valid, wdata/wstrb pass through, wr_ready=wready, wlast=(count==len); after last handshake go B.
REQ-020 B: bready=1; on bvalid latch resp, pulse done, go IDLE.
REQ-021 resp = max of all rresp/bresp in burst; cleared at command accept; held until next accept.
REQ-022 Idle-cycle counter resets on any AXI handshake; in non-IDLE reaching TIMEOUT sets timeout (sticky until reset); FSM keeps waiting, never drops valid.
REQ-023 Beat counter 8 bits, no wrap: len=255 gives 256 beats.
REQ-024 cmd_valid while busy ignored; cmd_ready=0 outside IDLE.
REQ-025 done is a single-cycle registered pulse.

Reset
REQ-026 All valids, readies, done, timeout, resp, counters = 0; state IDLE; addr/len/size/burst outputs = 0.
REQ-027 Reset mid-burst returns to IDLE immediately; no further beats driven.

Structure
REQ-028 Shared package: state enum, BURST_INCR=2'b01, RESP_OKAY/EXOKAY/SLVERR/DECERR constants.
REQ-029 One sub-module: axi4_beat_counter (len compare, last flag, watchdog).

Verification
REQ-030 Write addr 0x10000004, len 0, size 2, data 0x00f1001f, strb 0xF -> one AW, one W with wlast=1, bready, done, resp=0.
REQ-031 Read 0x10000004, len 1 -> arlen=1, two rd beats, rd_last on second only, done after second.
REQ-032 rd_ready low 3 cycles mid-burst -> rready low, no beat lost, data order preserved.
REQ-033 Slave bresp=2'b10 -> resp=2'b10 with done; next command clears it.
REQ-034 Slave never asserts arready, TIMEOUT=16 -> timeout=1 after 16 cycles, arvalid stays 1.
REQ-035 PRESETn low during beat 2 of len-3 read -> all outputs reset values next cycle, cmd_ready=1 after release.
